// File: rtl/spi_con.sv
// Shared constants and state encoding for the serial SRAM frame-store read path.
package spi_con;
  localparam int                    OPCODEBITS  = 8;
  localparam logic [OPCODEBITS-1:0] READ_OPCODE = 8'h03;
  localparam int                    ADDRESSBITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDRESS,
    DATA,
    FINISH
  } spi_rd_state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous show-ahead byte FIFO: the head entry is always visible on head while valid is high.
module spi_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != (AW + 1)'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // NOTE: storage is not reset; only pointers and count need defined values, so the array can map onto RAM.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);
endmodule

// File: rtl/spi_sram_reader.sv
// Sequential-read SPI master for the serial SRAM frame store; fills a pixel FIFO and pauses sck while it is full.
module spi_sram_reader
  import spi_con::*;
#(
  parameter int ADDRESSBITS = spi_con::ADDRESSBITS,
  parameter int LENBITS     = 10,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDRESSBITS-1:0]      start_addr,
  input  logic [LENBITS-1:0]          length,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        cs,
  output logic                        sck,
  output logic                        si,
  input  logic                        so,
  output logic [7:0]                  pix_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int SRW  = OPCODEBITS + ADDRESSBITS;
  localparam int CNTW = $clog2((ADDRESSBITS > OPCODEBITS) ? ADDRESSBITS : OPCODEBITS);

  localparam logic [CNTW-1:0] OP_LAST   = CNTW'(OPCODEBITS - 1);
  localparam logic [CNTW-1:0] ADDR_LAST = CNTW'(ADDRESSBITS - 1);
  localparam logic [CNTW-1:0] BYTE_LAST = CNTW'(7);

  spi_rd_state_t      state_q, state_d;
  logic               phase_q, phase_d;
  logic [CNTW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LENBITS-1:0] byte_cnt_q, byte_cnt_d;
  logic               waiting_q, waiting_d;
  logic               fin_q, fin_d;
  logic [SRW-1:0]     tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               si_q, si_d;
  logic               done_q, done_d;
  logic               zlen_q, zlen_d;

  logic push;
  logic pop;
  logic room_idle;
  logic room_push;

  // Room checks use the registered level only, so a pop never shortens a stall within the same cycle.
  assign room_idle = int'(fifo_level) < FIFO_DEPTH;
  assign room_push = int'(fifo_level) + 1 < FIFO_DEPTH;
  assign pop       = pix_valid && pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      waiting_q  <= 1'b0;
      fin_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      si_q       <= 1'b0;
      done_q     <= 1'b0;
      zlen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      waiting_q  <= waiting_d;
      fin_q      <= fin_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      si_q       <= si_d;
      done_q     <= done_d;
      zlen_q     <= zlen_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    waiting_d  = waiting_q;
    fin_d      = fin_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    si_d       = si_q;
    done_d     = 1'b0;
    zlen_d     = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (zlen_q) begin
          done_d = 1'b1;
        end else if (start) begin
          if (length == '0) begin
            zlen_d = 1'b1;
          end else begin
            state_d    = OPCODE;
            cs_d       = 1'b0;
            sck_d      = 1'b0;
            tx_d       = {READ_OPCODE, start_addr};
            si_d       = READ_OPCODE[OPCODEBITS-1];
            phase_d    = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = length;
            waiting_d  = 1'b0;
          end
        end
      end

      FINISH: begin
        if (fin_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          fin_d   = 1'b0;
        end else begin
          fin_d = 1'b1;
        end
      end

      default: begin
        if (abort) begin
          state_d   = FINISH;
          cs_d      = 1'b1;
          sck_d     = 1'b0;
          si_d      = 1'b0;
          fin_d     = 1'b0;
          waiting_d = 1'b0;
          phase_d   = 1'b0;
        end else if (!phase_q) begin
          if (state_q == DATA && waiting_q) begin
            if (room_idle) waiting_d = 1'b0;
          end else begin
            sck_d   = 1'b1;
            phase_d = 1'b1;
            if (state_q == DATA) rx_d = {rx_q[6:0], so};
          end
        end else begin
          sck_d     = 1'b0;
          phase_d   = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          case (state_q)
            OPCODE: begin
              tx_d = tx_q << 1;
              si_d = tx_q[SRW-2];
              if (bit_cnt_q == OP_LAST) begin
                state_d   = ADDRESS;
                bit_cnt_d = '0;
              end
            end
            ADDRESS: begin
              tx_d = tx_q << 1;
              si_d = tx_q[SRW-2];
              if (bit_cnt_q == ADDR_LAST) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                si_d      = 1'b0;
                waiting_d = !room_idle;
              end
            end
            DATA: begin
              if (bit_cnt_q == BYTE_LAST) begin
                push       = 1'b1;
                bit_cnt_d  = '0;
                byte_cnt_d = byte_cnt_q - 1'b1;
                if (byte_cnt_q == LENBITS'(1)) begin
                  state_d = FINISH;
                  cs_d    = 1'b1;
                  fin_d   = 1'b0;
                end else begin
                  waiting_d = !room_push;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  spi_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rx_q),
    .pop       (pop),
    .head      (pix_data),
    .valid     (pix_valid),
    .count     (fifo_level)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign cs   = cs_q;
  assign sck  = sck_q;
  assign si   = si_q;
endmodule
